// File: rtl/io_port_unit.sv
// Programmed-I/O port: INPR/OUTR registers with device valid/ready handshakes
// and the I/O flags seen by the control sequencer.
module io_port_unit #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dev_in_data,
    input  logic             dev_in_valid,
    output logic             dev_in_ready,
    output logic [WIDTH-1:0] dev_out_data,
    output logic             dev_out_valid,
    input  logic             dev_out_ready,
    input  logic             inpr_read,
    input  logic             outr_write,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_out_en,
    output logic             I_flag,
    output logic             O_flag
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {IN_EMPTY, IN_FULL, IN_DRAIN} in_state_t;
    typedef enum logic [1:0] {OUT_EMPTY, OUT_HOLD, OUT_FULL} out_state_t;

    in_state_t        in_state, in_next;
    logic [CW-1:0]    in_cnt, in_cnt_next;
    logic [WIDTH-1:0] inpr, inpr_next;

    out_state_t       out_state, out_next;
    logic [CW-1:0]    out_cnt, out_cnt_next;
    logic [WIDTH-1:0] outr, outr_next;
    // Remembers a consumption that happened while the flag hold was still running.
    logic             done, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state  <= IN_EMPTY;
            in_cnt    <= '0;
            inpr      <= '0;
            out_state <= OUT_EMPTY;
            out_cnt   <= '0;
            outr      <= '0;
            done      <= 1'b0;
        end else begin
            in_state  <= in_next;
            in_cnt    <= in_cnt_next;
            inpr      <= inpr_next;
            out_state <= out_next;
            out_cnt   <= out_cnt_next;
            outr      <= outr_next;
            done      <= done_next;
        end
    end

    always_comb begin
        in_next      = in_state;
        in_cnt_next  = in_cnt;
        inpr_next    = inpr;
        dev_in_ready = 1'b0;
        I_flag       = 1'b0;
        case (in_state)
            IN_EMPTY: begin
                dev_in_ready = 1'b1;
                if (dev_in_valid) begin
                    inpr_next = dev_in_data;
                    in_next   = IN_FULL;
                end
            end
            IN_FULL: begin
                I_flag = 1'b1;
                if (inpr_read) begin
                    in_cnt_next = HOLD_C;
                    in_next     = IN_DRAIN;
                end
            end
            IN_DRAIN: begin
                I_flag = 1'b1;
                if (in_cnt == '0) in_next = IN_EMPTY;
                else              in_cnt_next = in_cnt - ONE;
            end
            default: in_next = IN_EMPTY;
        endcase
    end

    always_comb begin
        out_next      = out_state;
        out_cnt_next  = out_cnt;
        outr_next     = outr;
        done_next     = done;
        dev_out_valid = 1'b0;
        O_flag        = 1'b0;
        case (out_state)
            OUT_EMPTY: begin
                O_flag = 1'b1;
                if (outr_write) begin
                    outr_next    = bus_in;
                    out_cnt_next = HOLD_C;
                    done_next    = 1'b0;
                    out_next     = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                O_flag        = 1'b1;
                dev_out_valid = 1'b1;
                if (dev_out_ready) done_next = 1'b1;
                if (out_cnt == '0)
                    out_next = (done || dev_out_ready) ? OUT_EMPTY : OUT_FULL;
                else
                    out_cnt_next = out_cnt - ONE;
            end
            OUT_FULL: begin
                dev_out_valid = 1'b1;
                if (dev_out_ready) out_next = OUT_EMPTY;
            end
            default: out_next = OUT_EMPTY;
        endcase
    end

    assign bus_out_en   = inpr_read;
    assign bus_out      = inpr_read ? inpr : '0;
    assign dev_out_data = outr;

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: directed test-plan steps followed by random traffic,
// compared every cycle against an event-timeline model of the port.
module tb_io_port_unit;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] dev_in_data;
    logic             dev_in_valid;
    logic             dev_in_ready;
    logic [WIDTH-1:0] dev_out_data;
    logic             dev_out_valid;
    logic             dev_out_ready;
    logic             inpr_read;
    logic             outr_write;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_out_en;
    logic             I_flag;
    logic             O_flag;

    io_port_unit #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
        .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
        .inpr_read(inpr_read), .outr_write(outr_write), .bus_in(bus_in),
        .bus_out(bus_out), .bus_out_en(bus_out_en), .I_flag(I_flag), .O_flag(O_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who holds data and the edge numbers at which flags change.
    logic [WIDTH-1:0] m_inpr, m_outr;
    bit               in_has, out_busy, out_cons;
    int               in_rel, out_w;
    int               ecount = 0;

    task automatic model_reset();
        m_inpr = '0; m_outr = '0;
        in_has = 0; in_rel = -1;
        out_busy = 0; out_cons = 0; out_w = 0;
    endtask

    task automatic model_edge();
        int cur = ecount;
        int e   = cur + 1;
        if (in_has && in_rel >= 0) begin
            if (e == in_rel) begin in_has = 0; in_rel = -1; end
        end else if (in_has) begin
            if (inpr_read) in_rel = e + HOLD + 1;
        end else if (dev_in_valid) begin
            m_inpr = dev_in_data; in_has = 1;
        end
        if (!out_busy) begin
            if (outr_write) begin m_outr = bus_in; out_busy = 1; out_w = e; out_cons = 0; end
        end else if (cur <= out_w + HOLD) begin
            if (dev_out_ready) out_cons = 1;
            if (e == out_w + HOLD + 1 && out_cons) out_busy = 0;
        end else if (dev_out_ready) begin
            out_busy = 0;
        end
        ecount = e;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string ph);
        check({ph, ".dev_in_ready"},  32'(dev_in_ready),  32'(!in_has));
        check({ph, ".I_flag"},        32'(I_flag),        32'(in_has));
        check({ph, ".bus_out_en"},    32'(bus_out_en),    32'(inpr_read));
        check({ph, ".bus_out"},       32'(bus_out),       inpr_read ? 32'(m_inpr) : 32'd0);
        check({ph, ".dev_out_data"},  32'(dev_out_data),  32'(m_outr));
        check({ph, ".dev_out_valid"}, 32'(dev_out_valid), 32'(out_busy));
        check({ph, ".O_flag"},        32'(O_flag),        32'(!(out_busy && ecount >= out_w + HOLD + 1)));
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic rd,
                         input logic wr, input logic [WIDTH-1:0] bi, input logic ordy);
        dev_in_valid = iv; dev_in_data = id; inpr_read = rd;
        outr_write = wr; bus_in = bi; dev_out_ready = ordy;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle(string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic async_reset(string ph);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        #1 rst = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        model_reset();
        @(negedge clk);
        check_all("por");
        rst = 1'b1;
        cycle("idle");

        // Test 1: async reset between edges with both ports busy
        drive(1, 8'h77, 0, 1, 8'h11, 0);
        cycle("t1_load");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("t1_busy");
        async_reset("t1_reset");
        cycle("t1_after");

        // Test 2: input path
        drive(1, 8'hA5, 0, 0, 8'h00, 0);
        cycle("t2_load");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("t2_full");
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        cycle("t2_read");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (4) cycle("t2_drain");

        // Test 3: back-pressure, 8'h3C waits for the drain; long read strobe
        drive(1, 8'hA5, 0, 0, 8'h00, 0);
        cycle("t3_load");
        drive(1, 8'h3C, 0, 0, 8'h00, 0);
        cycle("t3_blocked");
        drive(1, 8'h3C, 1, 0, 8'h00, 0);
        cycle("t3_read_a5");
        drive(1, 8'h3C, 0, 0, 8'h00, 0);
        repeat (4) cycle("t3_wait");
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        repeat (3) cycle("t3_read_3c");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (3) cycle("t3_drain");

        // Test 4: slow consumer
        drive(0, 8'h00, 0, 1, 8'h5A, 0);
        cycle("t4_write");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (5) cycle("t4_hold");
        drive(0, 8'h00, 0, 0, 8'h00, 1);
        cycle("t4_accept");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (2) cycle("t4_empty");

        // Test 5: fast consumer, ignored second write
        drive(0, 8'h00, 0, 1, 8'h5A, 1);
        cycle("t5_write");
        drive(0, 8'h00, 0, 1, 8'hFF, 1);
        cycle("t5_ignored");
        drive(0, 8'h00, 0, 0, 8'h00, 1);
        repeat (4) cycle("t5_fast");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("t5_idle");

        // Test 6: simultaneous strobes and a reset mid-drain
        drive(1, 8'h96, 0, 0, 8'h00, 0);
        cycle("t6_load");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("t6_full");
        drive(0, 8'h00, 1, 1, 8'hC3, 0);
        cycle("t6_both");
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("t6_drain");
        async_reset("t6_reset");
        repeat (3) cycle("t6_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 2) == 1, WIDTH'($urandom), ($urandom % 4) == 0,
                  ($urandom % 4) == 0, WIDTH'($urandom), ($urandom % 3) == 0);
            if (($urandom % 50) == 0) async_reset("rnd_reset");
            else                      cycle("rnd");
        end
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        cycle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
